t_stream_monitor: RTL and testbench

Downstream consumer of the single-bit selected output `T` produced by the flip-flop/MUX stage. It samples `T` under a sample enable, deserialises the stream into bytes delivered over a valid/ready handshake, and runs an overlapping sequence detector for the pattern 1011 with a saturating match counter. It lets the board readout or a testbench observe the muxed flip-flop behaviour as bytes and events, not as a raw bit.

---
 rtl/t_stream_monitor.sv | 112 +++++++++++
 tb/tb_t_stream_monitor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/t_stream_monitor.sv
// Serial monitor for the muxed flip-flop bit T: packs enabled samples into bytes
// behind a valid/ready register and counts overlapping 1011 detections.
module t_stream_monitor #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               T,
    input  logic               en,
    input  logic               byte_ready,
    output logic [7:0]         byte_data,
    output logic               byte_valid,
    output logic               overrun,
    output logic               match,
    output logic [COUNT_W-1:0] match_count
);

    typedef enum logic [1:0] {IDLE, S1, S10, S101} state_e;

    logic [6:0]         shreg_q, shreg_d;
    logic [2:0]         bitcnt_q, bitcnt_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic               ovr_q, ovr_d;
    logic               match_q, match_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    state_e             state_q, state_d;

    logic       done;
    logic       xfer;
    logic [7:0] new_byte;

    // Deserialiser; only the 7 oldest bits need storing, bit 8 arrives on T.
    always_comb begin
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        done     = 1'b0;
        new_byte = {shreg_q, T};
        if (en) begin
            shreg_d  = {shreg_q[5:0], T};
            bitcnt_d = bitcnt_q + 3'd1;
            done     = (bitcnt_q == 3'd7);
        end
    end

    // Output holding register: a completing byte may replace one leaving this edge.
    always_comb begin
        xfer    = valid_q & byte_ready;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (done) begin
            if (!valid_q || xfer) begin
                data_d  = new_byte;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        match_d = 1'b0;
        if (en) begin
            case (state_q)
                IDLE: state_d = T ? S1 : IDLE;
                S1:   state_d = T ? S1 : S10;
                S10:  state_d = T ? S101 : IDLE;
                S101: begin
                    state_d = T ? S1 : S10;
                    match_d = T;
                end
                default: state_d = IDLE;
            endcase
        end
        cnt_d = cnt_q;
        if (match_d && (cnt_q != {COUNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q  <= '0;
            bitcnt_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            match_q  <= 1'b0;
            cnt_q    <= '0;
            state_q  <= IDLE;
        end else begin
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
            match_q  <= match_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
        end
    end

    assign byte_data   = data_q;
    assign byte_valid  = valid_q;
    assign overrun     = ovr_q;
    assign match       = match_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_t_stream_monitor.sv
// Bench for t_stream_monitor: vector table, directed corner sequences and a
// randomized run against a bit-history reference model (two counter widths).
module tb_t_stream_monitor;

    logic       clk = 1'b0;
    logic       reset, T, en, byte_ready;
    logic [7:0] bd8, bd4;
    logic       bv8, bv4, ov8, ov4, m8, m4;
    logic [7:0] mc8;
    logic [3:0] mc4;

    t_stream_monitor #(.COUNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .T(T), .en(en), .byte_ready(byte_ready),
        .byte_data(bd8), .byte_valid(bv8), .overrun(ov8), .match(m8), .match_count(mc8));

    t_stream_monitor #(.COUNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .T(T), .en(en), .byte_ready(byte_ready),
        .byte_data(bd4), .byte_valid(bv4), .overrun(ov4), .match(m4), .match_count(mc4));

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model: history of sampled bits and the handshake rules.
    logic [7:0] m_hist, m_data;
    int         m_nb, m_cnt;
    logic       m_valid, m_ovr, m_match;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_clear();
        m_hist = '0; m_data = '0; m_nb = 0; m_cnt = 0;
        m_valid = 1'b0; m_ovr = 1'b0; m_match = 1'b0;
    endtask

    task automatic model_edge(input logic e, input logic t, input logic r);
        logic xfer, done;
        xfer    = m_valid && r;
        done    = 1'b0;
        m_match = 1'b0;
        if (e) begin
            m_hist = {m_hist[6:0], t};
            m_nb   = (m_nb + 1) % 8;
            done   = (m_nb == 0);
            if (m_hist[3:0] == 4'b1011) begin
                m_match = 1'b1;
                m_cnt++;
            end
        end
        if (done) begin
            if (!m_valid || xfer) begin
                m_data  = m_hist;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (xfer) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_data8"},  bd8, m_data);
        chk({tag, "_valid8"}, bv8, m_valid);
        chk({tag, "_ovr8"},   ov8, m_ovr);
        chk({tag, "_match8"}, m8,  m_match);
        chk({tag, "_cnt8"},   mc8, (m_cnt > 255) ? 255 : m_cnt);
        chk({tag, "_data4"},  bd4, m_data);
        chk({tag, "_valid4"}, bv4, m_valid);
        chk({tag, "_ovr4"},   ov4, m_ovr);
        chk({tag, "_match4"}, m4,  m_match);
        chk({tag, "_cnt4"},   mc4, (m_cnt > 15) ? 15 : m_cnt);
    endtask

    task automatic step(input logic e, input logic t, input logic r);
        en = e; T = t; byte_ready = r;
        @(posedge clk);
        model_edge(e, t, r);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic r, input string tag);
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, b[i], r);
            check_model(tag);
        end
    endtask

    // Reset pulse placed between edges; outputs must clear before the next edge.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        chk("rst_data", bd8, 8'h00);
        chk("rst_valid", bv8, 1'b0);
        chk("rst_ovr", ov8, 1'b0);
        chk("rst_match", m8, 1'b0);
        chk("rst_cnt", mc8, 8'h00);
        check_model("rst");
        reset = 1'b0;
    endtask

    typedef struct packed {
        logic [2:0] in;     // en, T, byte_ready
        logic [7:0] d;
        logic [2:0] fl;     // byte_valid, overrun, match
        logic [7:0] c;
    } vec_t;

    vec_t tbl [19];

    initial begin
        int nm;
        tbl = '{
            '{3'b111, 8'h00, 3'b000, 8'd0}, '{3'b101, 8'h00, 3'b000, 8'd0},
            '{3'b111, 8'h00, 3'b000, 8'd0}, '{3'b101, 8'h00, 3'b000, 8'd0},
            '{3'b101, 8'h00, 3'b000, 8'd0}, '{3'b111, 8'h00, 3'b000, 8'd0},
            '{3'b101, 8'h00, 3'b000, 8'd0}, '{3'b111, 8'hA5, 3'b100, 8'd0},
            '{3'b001, 8'hA5, 3'b000, 8'd0}, '{3'b101, 8'hA5, 3'b000, 8'd0},
            '{3'b101, 8'hA5, 3'b000, 8'd0}, '{3'b111, 8'hA5, 3'b000, 8'd0},
            '{3'b101, 8'hA5, 3'b000, 8'd0}, '{3'b111, 8'hA5, 3'b000, 8'd0},
            '{3'b111, 8'hA5, 3'b001, 8'd1}, '{3'b101, 8'hA5, 3'b000, 8'd1},
            '{3'b111, 8'h2D, 3'b100, 8'd1}, '{3'b111, 8'h2D, 3'b001, 8'd2},
            '{3'b001, 8'h2D, 3'b000, 8'd2}
        };
        reset = 1'b1; T = 1'b0; en = 1'b0; byte_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        reset = 1'b0;

        // Basic byte A5 then an overlapping 1011011 run.
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
            chk($sformatf("tbl%0d_data", i),  bd8, tbl[i].d);
            chk($sformatf("tbl%0d_valid", i), bv8, tbl[i].fl[2]);
            chk($sformatf("tbl%0d_ovr", i),   ov8, tbl[i].fl[1]);
            chk($sformatf("tbl%0d_match", i), m8,  tbl[i].fl[0]);
            chk($sformatf("tbl%0d_cnt", i),   mc8, tbl[i].c);
            check_model("tblm");
        end

        // Reset mid-byte discards the partial byte.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        do_reset();
        send_byte(8'hA5, 1'b0, "midrst");
        chk("midrst_byte", bd8, 8'hA5);
        chk("midrst_valid", bv8, 1'b1);

        // Backpressure: second byte is dropped, overrun sticks.
        do_reset();
        send_byte(8'h3C, 1'b0, "bp1");
        send_byte(8'hFF, 1'b0, "bp2");
        chk("bp_hold", bd8, 8'h3C);
        chk("bp_ovr", ov8, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check_model("bp3");
        chk("bp_drain_valid", bv8, 1'b0);
        chk("bp_ovr_sticky", ov8, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("bp_ovr_sticky2", ov8, 1'b1);

        // Enable gaps with junk on T.
        do_reset();
        nm = 0;
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] pat;
            pat = 8'hA5;
            step(1'b1, pat[i], 1'b0);
            nm += int'(m8);
            check_model("gap");
            for (int g = 0; g < 3; g++) begin
                step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
                nm += int'(m8);
                check_model("gapj");
            end
        end
        chk("gap_byte", bd8, 8'hA5);
        chk("gap_no_match", nm, 0);

        // Saturation of the narrow counter.
        do_reset();
        nm = 0;
        for (int r = 0; r < 20; r++) begin
            step(1'b1, 1'b1, 1'b1); check_model("sat");
            step(1'b1, 1'b0, 1'b1); check_model("sat");
            step(1'b1, 1'b1, 1'b1); check_model("sat");
            step(1'b1, 1'b1, 1'b1); check_model("sat");
            chk("sat_pulse", m4, 1'b1);
            nm += int'(m4);
        end
        chk("sat_pulses", nm, 20);
        chk("sat_cnt4", mc4, 4'd15);
        chk("sat_cnt8", mc8, 8'd20);
        step(1'b0, 1'b1, 1'b1);
        chk("sat_match_clear", m4, 1'b0);
        chk("sat_cnt4_hold", mc4, 4'd15);

        // Randomized run: random backpressure, then ready tied high.
        do_reset();
        for (int i = 0; i < 1200; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 (i >= 600) ? 1'b1 : ($urandom_range(0, 1) != 0));
            check_model("rnd");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
